// File: rtl/iob_ibex2axi_pkg.sv
// Shared constants and types for the Ibex LSU to AXI4 bridge.
package iob_ibex2axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_NONE = 4'b0000;
  localparam logic [3:0] AXI_QOS_NONE   = 4'b0000;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

  // SLVERR and DECERR both carry bit 1 set.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/iob_ibex2axi_ostd.sv
// Outstanding-transaction tracker: counter, direction register, grant
// qualification and response acceptance.
module iob_ibex2axi_ostd
  import iob_ibex2axi_pkg::*;
#(
  parameter int unsigned MAX_OSTD = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic clk_i,
  input  logic cke_i,
  input  logic arst_i,
  input  logic req_i,
  input  logic we_i,
  input  logic slot_free_i,
  input  logic r_beat_i,
  input  logic b_beat_i,
  output logic gnt_o,
  output logic r_acc_o,
  output logic b_acc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_e             dir_q;
  logic             cnt_zero;
  logic             room;
  logic             dir_ok;
  logic             rsp;

  assign cnt_zero = (cnt_q == '0);
  assign room     = (cnt_q < CNT_W'(MAX_OSTD));
  assign dir_ok   = cnt_zero || (dir_e'(we_i) == dir_q);

  // Grant is withheld while the clock is disabled so that no request is lost.
  assign gnt_o    = cke_i & req_i & room & dir_ok & slot_free_i;

  // Responses are only accepted when a matching transaction is outstanding.
  assign r_acc_o  = r_beat_i & ~cnt_zero & (dir_q == DIR_RD);
  assign b_acc_o  = b_beat_i & ~cnt_zero & (dir_q == DIR_WR);
  assign rsp      = r_acc_o | b_acc_o;

  // Next outstanding count: simultaneous grant and response cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (gnt_o && !rsp) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!gnt_o && rsp) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter and direction registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
      dir_q <= DIR_RD;
    end else if (cke_i) begin
      cnt_q <= cnt_d;
      if (gnt_o && cnt_zero) begin
        dir_q <= dir_e'(we_i);
      end
    end
  end

endmodule

// File: rtl/iob_ibex2axi_mo.sv
// Ibex LSU to AXI4 single-beat bridge with multiple outstanding transactions.
// Optional macro IOB_IBEX2AXI_ID_CHK_EN enables ID/RLAST/stray-response
// checking with a sticky protocol-error flag.
module iob_ibex2axi_mo
  import iob_ibex2axi_pkg::*;
#(
  parameter int unsigned         AXI_ID_W    = 1,
  parameter int unsigned         AXI_ADDR_W  = 32,
  parameter int unsigned         AXI_DATA_W  = 32,
  parameter int unsigned         AXI_LEN_W   = 8,
  parameter int unsigned         IBEX_ADDR_W = 32,
  parameter int unsigned         MAX_OSTD    = 4,
  parameter logic [AXI_ID_W-1:0] AXI_ID      = '0,
  parameter logic [2:0]          AXI_PROT    = 3'b000
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_i,
  // Ibex LSU
  input  logic                    ibex_req_i,
  input  logic                    ibex_we_i,
  input  logic [3:0]              ibex_be_i,
  input  logic [IBEX_ADDR_W-1:0]  ibex_addr_i,
  input  logic [31:0]             ibex_wdata_i,
  output logic                    ibex_gnt_o,
  output logic                    ibex_rvalid_o,
  output logic [31:0]             ibex_rdata_o,
  output logic                    ibex_err_o,
  // AW
  output logic                    awvalid_o,
  output logic [AXI_ADDR_W-1:0]   awaddr_o,
  output logic [AXI_ID_W-1:0]     awid_o,
  output logic [AXI_LEN_W-1:0]    awlen_o,
  output logic [2:0]              awsize_o,
  output logic [1:0]              awburst_o,
  output logic                    awlock_o,
  output logic [3:0]              awcache_o,
  output logic [3:0]              awqos_o,
  output logic [2:0]              awprot_o,
  input  logic                    awready_i,
  // W
  output logic                    wvalid_o,
  output logic [AXI_DATA_W-1:0]   wdata_o,
  output logic [3:0]              wstrb_o,
  output logic                    wlast_o,
  input  logic                    wready_i,
  // B
  input  logic                    bvalid_i,
  input  logic [1:0]              bresp_i,
  input  logic [AXI_ID_W-1:0]     bid_i,
  output logic                    bready_o,
  // AR
  output logic                    arvalid_o,
  output logic [AXI_ADDR_W-1:0]   araddr_o,
  output logic [AXI_ID_W-1:0]     arid_o,
  output logic [AXI_LEN_W-1:0]    arlen_o,
  output logic [2:0]              arsize_o,
  output logic [1:0]              arburst_o,
  output logic                    arlock_o,
  output logic [3:0]              arcache_o,
  output logic [3:0]              arqos_o,
  output logic [2:0]              arprot_o,
  input  logic                    arready_i,
  // R
  input  logic                    rvalid_i,
  input  logic [AXI_DATA_W-1:0]   rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic [AXI_ID_W-1:0]     rid_i,
  input  logic                    rlast_i,
  output logic                    rready_o,
  output logic                    prot_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OSTD + 1);

  logic                  ar_valid_q;
  logic [AXI_ADDR_W-1:0] ar_addr_q;
  logic                  aw_valid_q;
  logic [AXI_ADDR_W-1:0] aw_addr_q;
  logic                  w_valid_q;
  logic [AXI_DATA_W-1:0] w_data_q;
  logic [3:0]            w_strb_q;

  logic                  rsp_valid_q;
  logic [31:0]           rsp_data_q;
  logic                  rsp_err_q;

  logic                  gnt;
  logic                  slot_free;
  logic                  r_acc;
  logic                  b_acc;
  logic [AXI_ADDR_W-1:0] req_addr;
  logic                  r_bad;
  logic                  b_bad;
  logic                  stray;

  assign req_addr  = {ibex_addr_i[AXI_ADDR_W-1:2], 2'b00};
  assign slot_free = ibex_we_i ? (~aw_valid_q & ~w_valid_q) : ~ar_valid_q;

  iob_ibex2axi_ostd #(
    .MAX_OSTD (MAX_OSTD),
    .CNT_W    (CNT_W)
  ) u_ostd (
    .clk_i       (clk_i),
    .cke_i       (cke_i),
    .arst_i      (arst_i),
    .req_i       (ibex_req_i),
    .we_i        (ibex_we_i),
    .slot_free_i (slot_free),
    .r_beat_i    (rvalid_i),
    .b_beat_i    (bvalid_i),
    .gnt_o       (gnt),
    .r_acc_o     (r_acc),
    .b_acc_o     (b_acc)
  );

  assign ibex_gnt_o = gnt;

  // Read address channel register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
    end else if (cke_i) begin
      if (gnt && !ibex_we_i) begin
        ar_valid_q <= 1'b1;
        ar_addr_q  <= req_addr;
      end else if (ar_valid_q && arready_i) begin
        ar_valid_q <= 1'b0;
      end
    end
  end

  // Write address channel register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      aw_valid_q <= 1'b0;
      aw_addr_q  <= '0;
    end else if (cke_i) begin
      if (gnt && ibex_we_i) begin
        aw_valid_q <= 1'b1;
        aw_addr_q  <= req_addr;
      end else if (aw_valid_q && awready_i) begin
        aw_valid_q <= 1'b0;
      end
    end
  end

  // Write data channel register, completes independently of AW.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (cke_i) begin
      if (gnt && ibex_we_i) begin
        w_valid_q <= 1'b1;
        w_data_q  <= ibex_wdata_i;
        w_strb_q  <= ibex_be_i;
      end else if (w_valid_q && wready_i) begin
        w_valid_q <= 1'b0;
      end
    end
  end

`ifdef IOB_IBEX2AXI_ID_CHK_EN
  logic prot_err_q;

  assign r_bad = (rid_i != AXI_ID) | ~rlast_i;
  assign b_bad = (bid_i != AXI_ID);
  assign stray = (rvalid_i & ~r_acc) | (bvalid_i & ~b_acc);

  // Sticky protocol-error flag.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      prot_err_q <= 1'b0;
    end else if (cke_i) begin
      if ((r_acc && r_bad) || (b_acc && b_bad) || stray) begin
        prot_err_q <= 1'b1;
      end
    end
  end

  assign prot_err_o = prot_err_q;
`else
  logic unused_id_chk;

  assign r_bad         = 1'b0;
  assign b_bad         = 1'b0;
  assign stray         = 1'b0;
  assign unused_id_chk = ^{rid_i, bid_i, rlast_i, stray};
  assign prot_err_o    = 1'b0;
`endif

  // Response stage: one-cycle pulse to Ibex per accepted R or B beat.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else if (cke_i) begin
      rsp_valid_q <= r_acc | b_acc;
      if (r_acc) begin
        rsp_data_q <= rdata_i;
        rsp_err_q  <= resp_is_err(rresp_i) | r_bad;
      end else if (b_acc) begin
        rsp_data_q <= '0;
        rsp_err_q  <= resp_is_err(bresp_i) | b_bad;
      end
    end
  end

  logic unused_in;
  assign unused_in = ^{ibex_addr_i, rresp_i[0], bresp_i[0]};

  assign ibex_rvalid_o = rsp_valid_q;
  assign ibex_rdata_o  = rsp_data_q;
  assign ibex_err_o    = rsp_err_q;

  assign awvalid_o = aw_valid_q;
  assign awaddr_o  = aw_addr_q;
  assign awid_o    = AXI_ID;
  assign awlen_o   = '0;
  assign awsize_o  = AXI_SIZE_4B;
  assign awburst_o = AXI_BURST_INCR;
  assign awlock_o  = 1'b0;
  assign awcache_o = AXI_CACHE_NONE;
  assign awqos_o   = AXI_QOS_NONE;
  assign awprot_o  = AXI_PROT;

  assign wvalid_o  = w_valid_q;
  assign wdata_o   = w_data_q;
  assign wstrb_o   = w_strb_q;
  assign wlast_o   = 1'b1;

  assign bready_o  = 1'b1;

  assign arvalid_o = ar_valid_q;
  assign araddr_o  = ar_addr_q;
  assign arid_o    = AXI_ID;
  assign arlen_o   = '0;
  assign arsize_o  = AXI_SIZE_4B;
  assign arburst_o = AXI_BURST_INCR;
  assign arlock_o  = 1'b0;
  assign arcache_o = AXI_CACHE_NONE;
  assign arqos_o   = AXI_QOS_NONE;
  assign arprot_o  = AXI_PROT;

  assign rready_o  = 1'b1;

endmodule

// File: tb/tb_iob_ibex2axi_mo.sv
// Directed self-checking bench for iob_ibex2axi_mo with a response scoreboard.
module tb_iob_ibex2axi_mo;
  import iob_ibex2axi_pkg::*;

  logic        clk = 1'b0;
  logic        cke, arst;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, ibex_rvalid, ibex_err;
  logic [31:0] ibex_rdata;
  logic        awvalid, awlock, awready, wvalid, wlast, wready;
  logic [31:0] awaddr, araddr, wdata_o, rdata;
  logic [0:0]  awid, arid, bid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  awcache, awqos, arcache, arqos, wstrb;
  logic        bvalid, bready, arvalid, arlock, arready;
  logic        rvalid, rlast, rready, prot_err;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] sb[$];   // {data, err}
  int          ng;
  logic        exp_prot;

  always #5 clk = ~clk;

  iob_ibex2axi_mo #(
    .MAX_OSTD (4)
  ) u_dut (
    .clk_i (clk), .cke_i (cke), .arst_i (arst),
    .ibex_req_i (req), .ibex_we_i (we), .ibex_be_i (be), .ibex_addr_i (addr),
    .ibex_wdata_i (wdata), .ibex_gnt_o (gnt), .ibex_rvalid_o (ibex_rvalid),
    .ibex_rdata_o (ibex_rdata), .ibex_err_o (ibex_err),
    .awvalid_o (awvalid), .awaddr_o (awaddr), .awid_o (awid), .awlen_o (awlen),
    .awsize_o (awsize), .awburst_o (awburst), .awlock_o (awlock),
    .awcache_o (awcache), .awqos_o (awqos), .awprot_o (awprot), .awready_i (awready),
    .wvalid_o (wvalid), .wdata_o (wdata_o), .wstrb_o (wstrb), .wlast_o (wlast),
    .wready_i (wready),
    .bvalid_i (bvalid), .bresp_i (bresp), .bid_i (bid), .bready_o (bready),
    .arvalid_o (arvalid), .araddr_o (araddr), .arid_o (arid), .arlen_o (arlen),
    .arsize_o (arsize), .arburst_o (arburst), .arlock_o (arlock),
    .arcache_o (arcache), .arqos_o (arqos), .arprot_o (arprot), .arready_i (arready),
    .rvalid_i (rvalid), .rdata_i (rdata), .rresp_i (rresp), .rid_i (rid),
    .rlast_i (rlast), .rready_o (rready), .prot_err_o (prot_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every Ibex response must match the oldest expectation.
  always @(negedge clk) begin
    if (ibex_rvalid) begin
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", 64'(ibex_rvalid), 64'd0);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("rsp_data", 64'(ibex_rdata), 64'(e[32:1]));
        chk("rsp_err", 64'(ibex_err), 64'(e[0]));
      end
    end
  end

  initial begin
    cke = 1'b1; arst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rid = '0; rlast = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", 64'(ibex_rvalid), 64'd0);
    chk("rst_err", 64'(ibex_err), 64'd0);
    chk("rst_rdata", 64'(ibex_rdata), 64'd0);
    chk("rst_prot", 64'(prot_err), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_cnt", 64'(u_dut.u_ostd.cnt_q), 64'd0);
    arst = 1'b0;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rready_const", 64'(rready), 64'd1);
    chk("bready_const", 64'(bready), 64'd1);
    tick();

    // Single read, zero-wait AXI: AR at cycle 1, Ibex rvalid at cycle 3.
    req = 1'b1; we = 1'b0; addr = 32'h0000_0100; arready = 1'b1;
    #1;
    chk("t1_gnt", 64'(gnt), 64'd1);
    sb.push_back({32'hDEAD_BEEF, 1'b0});
    tick(); req = 1'b0; #1;
    chk("t1_arvalid_c1", 64'(arvalid), 64'd1);
    chk("t1_araddr", 64'(araddr), 64'h100);
    chk("t1_arlen", 64'(arlen), 64'd0);
    chk("t1_arsize", 64'(arsize), 64'd2);
    chk("t1_arburst", 64'(arburst), 64'd1);
    chk("t1_arid", 64'(arid), 64'd0);
    tick(); rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = AXI_RESP_OKAY; #1;
    chk("t1_arvalid_c2", 64'(arvalid), 64'd0);
    chk("t1_rvalid_c2", 64'(ibex_rvalid), 64'd0);
    tick(); rvalid = 1'b0; #1;
    chk("t1_rvalid_c3", 64'(ibex_rvalid), 64'd1);
    tick();
    chk("t1_rvalid_c4", 64'(ibex_rvalid), 64'd0);

    // Back-to-back reads with R withheld: outstanding limit of 4.
    ng = 0; req = 1'b1; we = 1'b0;
    for (int c = 0; c < 12; c++) begin
      addr = 32'h0000_0200 + 32'(ng * 4) + 32'd3;
      #1;
      if (gnt) begin
        sb.push_back({32'hA000_0000 + 32'(ng), 1'b0});
        ng++;
      end
      tick();
    end
    chk("t2_ngrants", 64'(ng), 64'd4);
    chk("t2_cnt_full", 64'(u_dut.u_ostd.cnt_q), 64'd4);
    chk("t2_araddr_align", 64'(araddr), 64'h20C);
    rvalid = 1'b1; rdata = 32'hA000_0000;
    #1;
    chk("t2_gnt_during_r", 64'(gnt), 64'd0);
    tick(); rvalid = 1'b0; addr = 32'h0000_0210; #1;
    chk("t2_gnt5", 64'(gnt), 64'd1);
    sb.push_back({32'hA000_0004, 1'b0});
    tick(); rvalid = 1'b1; rdata = 32'hA000_0001; #1;
    chk("t2_gnt_full_again", 64'(gnt), 64'd0);
    tick(); rvalid = 1'b0; addr = 32'h0000_0214; #1;
    chk("t2_gnt6", 64'(gnt), 64'd1);
    sb.push_back({32'hA000_0005, 1'b0});
    tick(); req = 1'b0;
    for (int b = 2; b < 6; b++) begin
      rvalid = 1'b1; rdata = 32'hA000_0000 + 32'(b);
      tick();
    end
    rvalid = 1'b0;
    tick(); tick();
    chk("t2_cnt_drained", 64'(u_dut.u_ostd.cnt_q), 64'd0);

    // Write with W accepted three cycles before AW.
    arready = 1'b0;
    req = 1'b1; we = 1'b1; addr = 32'h0000_0300; wdata = 32'h55AA_00FF; be = 4'b0011;
    #1;
    chk("t3_gnt", 64'(gnt), 64'd1);
    sb.push_back({32'h0, 1'b0});
    tick(); req = 1'b0; #1;
    chk("t3_awvalid", 64'(awvalid), 64'd1);
    chk("t3_wvalid", 64'(wvalid), 64'd1);
    chk("t3_wdata", 64'(wdata_o), 64'h55AA_00FF);
    chk("t3_wstrb", 64'(wstrb), 64'h3);
    chk("t3_wlast", 64'(wlast), 64'd1);
    chk("t3_awaddr", 64'(awaddr), 64'h300);
    wready = 1'b1;
    tick(); wready = 1'b0; #1;
    chk("t3_wvalid_dropped", 64'(wvalid), 64'd0);
    chk("t3_awvalid_held1", 64'(awvalid), 64'd1);
    tick(); #1;
    chk("t3_awvalid_held2", 64'(awvalid), 64'd1);
    tick(); awready = 1'b1; #1;
    chk("t3_awvalid_held3", 64'(awvalid), 64'd1);
    chk("t3_awaddr_stable", 64'(awaddr), 64'h300);
    tick(); awready = 1'b0; bvalid = 1'b1; bresp = AXI_RESP_OKAY; #1;
    chk("t3_awvalid_done", 64'(awvalid), 64'd0);
    tick(); bvalid = 1'b0; #1;
    chk("t3_rvalid", 64'(ibex_rvalid), 64'd1);
    tick();

    // Read blocked behind two outstanding writes.
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    req = 1'b1; we = 1'b1; addr = 32'h0000_0400; wdata = 32'h1; be = 4'hF;
    #1;
    chk("t4_w1_gnt", 64'(gnt), 64'd1);
    sb.push_back({32'h0, 1'b0});
    tick(); #1;
    chk("t4_slot_busy", 64'(gnt), 64'd0);
    tick(); addr = 32'h0000_0404; #1;
    chk("t4_w2_gnt", 64'(gnt), 64'd1);
    sb.push_back({32'h0, 1'b0});
    tick(); we = 1'b0; addr = 32'h0000_0500; bvalid = 1'b1; #1;
    chk("t4_rd_blocked2", 64'(gnt), 64'd0);
    tick(); bvalid = 1'b0; #1;
    chk("t4_rd_blocked1", 64'(gnt), 64'd0);
    tick(); bvalid = 1'b1; #1;
    chk("t4_rd_blocked1b", 64'(gnt), 64'd0);
    tick(); bvalid = 1'b0; #1;
    chk("t4_rd_gnt", 64'(gnt), 64'd1);
    sb.push_back({32'hBAD0_BAD0, 1'b1});
    tick(); req = 1'b0; #1;
    chk("t4_dir_rd", 64'(u_dut.u_ostd.dir_q), 64'(DIR_RD));
    chk("t4_cnt", 64'(u_dut.u_ostd.cnt_q), 64'd1);
    tick(); rvalid = 1'b1; rdata = 32'hBAD0_BAD0; rresp = AXI_RESP_SLVERR;
    tick(); rvalid = 1'b0; rresp = AXI_RESP_OKAY;
    tick(); tick();

    // Read returned with a mismatching RID.
`ifdef IOB_IBEX2AXI_ID_CHK_EN
    exp_prot = 1'b1;
`else
    exp_prot = 1'b0;
`endif
    req = 1'b1; we = 1'b0; addr = 32'h0000_0600;
    #1;
    chk("t5_gnt", 64'(gnt), 64'd1);
    sb.push_back({32'hCAFE_F00D, exp_prot});
    tick(); req = 1'b0;
    tick(); rvalid = 1'b1; rdata = 32'hCAFE_F00D; rid = 1'b1;
    tick(); rvalid = 1'b0; rid = 1'b0; #1;
    chk("t5_prot", 64'(prot_err), 64'(exp_prot));
    tick(); tick();
    chk("t5_prot_sticky", 64'(prot_err), 64'(exp_prot));

    // Reset with three reads in flight, then stray R beats.
    ng = 0; req = 1'b1; we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      addr = 32'h0000_0700 + 32'(ng * 4);
      #1;
      if (gnt) ng++;
      tick();
    end
    req = 1'b0;
    chk("t6_ngrants", 64'(ng), 64'd3);
    chk("t6_cnt3", 64'(u_dut.u_ostd.cnt_q), 64'd3);
    arst = 1'b1; #1;
    chk("t6_async_cnt", 64'(u_dut.u_ostd.cnt_q), 64'd0);
    chk("t6_async_prot", 64'(prot_err), 64'd0);
    tick(); arst = 1'b0;
    tick();
    for (int b = 0; b < 3; b++) begin
      rvalid = 1'b1; rdata = 32'h7700_0000 + 32'(b);
      tick(); rvalid = 1'b0; #1;
      chk("t6_no_rvalid", 64'(ibex_rvalid), 64'd0);
      chk("t6_cnt0", 64'(u_dut.u_ostd.cnt_q), 64'd0);
    end
    tick();
    chk("t6_prot_stray", 64'(prot_err), 64'(exp_prot));
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
